vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_pkg.sv | 30 +++
 rtl/vga_timing_gen_if.sv | 26 ++
 rtl/vga_axis_counter.sv | 36 +++
 rtl/vga_timing_gen.sv | 103 ++++++++++
 tb/tb_vga_timing_gen.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: default 640x480@60 constants, per-axis segment
// struct and the counter-width helper used by the generator and its axis counters.
package vga_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    typedef struct packed {
        int unsigned active;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
    } seg_t;

    // Never returns 0 so a degenerate total still yields a legal vector width.
    function automatic int unsigned cnt_w(input int unsigned total);
        return (total <= 1) ? 1 : $clog2(total);
    endfunction

    function automatic int unsigned seg_total(input seg_t s);
        return s.active + s.fp + s.sync + s.bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video timing bundle: the generator drives sync/position/markers, the consumer drives en.
interface vga_timing_gen_if #(
    parameter int XW = 10,
    parameter int YW = 10
);
    logic          en;
    logic          pix_tick;
    logic          hsync;
    logic          vsync;
    logic          active;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          line_start;
    logic          frame_start;
    logic          vblank;

    modport master (
        input  en,
        output pix_tick, hsync, vsync, active, x, y, line_start, frame_start, vblank
    );

    modport slave (
        output en,
        input  pix_tick, hsync, vsync, active, x, y, line_start, frame_start, vblank
    );
endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter plus active/sync window decode.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         step,
    input  seg_t         seg,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         in_active,
    output logic         in_sync
);
    int unsigned cnt_i;
    int unsigned sync_lo;
    int unsigned sync_hi;

    always_comb begin
        cnt_i     = 32'(count);
        sync_lo   = seg.active + seg.fp;
        sync_hi   = sync_lo + seg.sync;
        wrap      = (cnt_i == seg_total(seg) - 1);
        in_active = (cnt_i < seg.active);
        in_sync   = (cnt_i >= sync_lo) && (cnt_i < sync_hi);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (step) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end
endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: clock prescaler, H/V axis counters and registered decode
// of sync, active window, pixel position and line/frame markers.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned XW       = 10,
    parameter int unsigned YW       = 10
) (
    input  logic              clk,
    input  logic              rst,
    vga_timing_gen_if.master  vid
);
    localparam seg_t        H_SEG   = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
    localparam seg_t        V_SEG   = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
    localparam int unsigned H_TOTAL = seg_total(H_SEG);
    localparam int unsigned V_TOTAL = seg_total(V_SEG);
    localparam int unsigned HW      = cnt_w(H_TOTAL);
    localparam int unsigned VW      = cnt_w(V_TOTAL);
    localparam int unsigned PW      = cnt_w(CLK_DIV);

    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
        CLK_DIV == 0 || XW < cnt_w(H_ACTIVE) || YW < cnt_w(V_ACTIVE)) begin : g_param_err
        $error("vga_timing_gen: illegal timing parameters");
    end

    logic [PW-1:0] psc;
    logic          tick;
    logic [HW-1:0] hc;
    logic [VW-1:0] vc;
    logic          h_wrap, h_act, h_sync;
    logic          v_wrap, v_act, v_sync;
    logic          unused_ok;

    // Gated by rst so a reset cycle can never emit a pixel pulse.
    assign tick         = vid.en && !rst && (psc == PW'(CLK_DIV - 1));
    assign vid.pix_tick = tick;
    assign unused_ok    = &{1'b1, v_wrap};

    always_ff @(posedge clk) begin
        if (rst) begin
            psc <= '0;
        end else if (vid.en) begin
            psc <= (psc == PW'(CLK_DIV - 1)) ? '0 : psc + 1'b1;
        end
    end

    vga_axis_counter #(.W(HW)) u_h (
        .clk       (clk),
        .rst       (rst),
        .step      (tick),
        .seg       (H_SEG),
        .count     (hc),
        .wrap      (h_wrap),
        .in_active (h_act),
        .in_sync   (h_sync)
    );

    vga_axis_counter #(.W(VW)) u_v (
        .clk       (clk),
        .rst       (rst),
        .step      (tick && h_wrap),
        .seg       (V_SEG),
        .count     (vc),
        .wrap      (v_wrap),
        .in_active (v_act),
        .in_sync   (v_sync)
    );

    // Decode describes the position current during the tick, so it lags hc/vc by one pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            vid.hsync       <= ~HS_POL;
            vid.vsync       <= ~VS_POL;
            vid.active      <= 1'b0;
            vid.x           <= '0;
            vid.y           <= '0;
            vid.line_start  <= 1'b0;
            vid.frame_start <= 1'b0;
            vid.vblank      <= 1'b0;
        end else if (tick) begin
            vid.hsync       <= h_sync ? HS_POL : ~HS_POL;
            vid.vsync       <= v_sync ? VS_POL : ~VS_POL;
            vid.active      <= h_act && v_act;
            vid.x           <= (h_act && v_act) ? XW'(hc) : '0;
            vid.y           <= (h_act && v_act) ? YW'(vc) : '0;
            vid.line_start  <= (hc == '0);
            vid.frame_start <= (hc == '0) && (vc == '0);
            vid.vblank      <= !v_act;
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: stimulus queues tick-tagged expected pixels, negedge monitors
// count completed ticks per DUT and compare when a tag comes due.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.XW(10), .YW(10)) va ();
    vga_timing_gen_if #(.XW(4),  .YW(3))  vb ();

    vga_timing_gen dut_a (.clk(clk), .rst(rst), .vid(va));

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(1), .XW(4), .YW(3)
    ) dut_b (.clk(clk), .rst(rst), .vid(vb));

    // fl = {active, hsync, vsync, line_start, frame_start, vblank}
    typedef struct {
        int         tick;
        int         x;
        int         y;
        logic [5:0] fl;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   errors = 0;
    int   n_a = 0;
    int   n_b = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void pa(input int p, input int x, input int y, input logic [5:0] fl);
        exp_t e;
        e.tick = p + 1; e.x = x; e.y = y; e.fl = fl;
        qa.push_back(e);
    endfunction

    function automatic void pb(input int p, input int x, input int y, input logic [5:0] fl);
        exp_t e;
        e.tick = p + 1; e.x = x; e.y = y; e.fl = fl;
        qb.push_back(e);
    endfunction

    // Inputs change just after posedges, so a negedge sample of pix_tick/rst is
    // exactly what the following posedge acts on.
    bit pend_a = 0, rstp_a = 0;
    int clk_a = 0, last_a = -1, per_a = 0, hs_low = 0;
    always @(negedge clk) begin
        clk_a++;
        if (rstp_a) begin
            n_a    = 0;
            last_a = -1;
        end else if (pend_a) begin
            n_a++;
            if (n_a <= 800 && va.hsync == 1'b0) hs_low++;
            if (n_a == 800) check("a.hsync_low_ticks_line0", hs_low, 96);
            while (qa.size() > 0 && qa[0].tick <= n_a) begin
                exp_t e;
                e = qa.pop_front();
                if (e.tick < n_a) check($sformatf("a.missed_tick%0d", e.tick), n_a, e.tick);
                else begin
                    check($sformatf("a.x@tick%0d", n_a), int'(va.x), e.x);
                    check($sformatf("a.y@tick%0d", n_a), int'(va.y), e.y);
                    check($sformatf("a.flags@tick%0d", n_a),
                          int'({va.active, va.hsync, va.vsync, va.line_start, va.frame_start, va.vblank}),
                          int'(e.fl));
                end
            end
        end
        if (va.pix_tick) begin
            if (last_a >= 0 && per_a < 8) begin
                check("a.tick_period_clks", clk_a - last_a, 4);
                per_a++;
            end
            last_a = clk_a;
        end
        pend_a = va.pix_tick;
        rstp_a = rst;
    end

    bit pend_b = 0, rstp_b = 0;
    int hs_hi = 0, fs_cnt = 0;
    always @(negedge clk) begin
        if (rstp_b) begin
            n_b = 0;
        end else if (pend_b) begin
            n_b++;
            if (n_b <= 14 && vb.hsync == 1'b1) hs_hi++;
            if (n_b <= 114 && vb.frame_start == 1'b1) fs_cnt++;
            if (n_b == 14)  check("b.hsync_high_ticks_line0", hs_hi, 3);
            if (n_b == 114) check("b.frame_starts_in_114_ticks", fs_cnt, 2);
            while (qb.size() > 0 && qb[0].tick <= n_b) begin
                exp_t e;
                e = qb.pop_front();
                if (e.tick < n_b) check($sformatf("b.missed_tick%0d", e.tick), n_b, e.tick);
                else begin
                    check($sformatf("b.x@tick%0d", n_b), int'(vb.x), e.x);
                    check($sformatf("b.y@tick%0d", n_b), int'(vb.y), e.y);
                    check($sformatf("b.flags@tick%0d", n_b),
                          int'({vb.active, vb.hsync, vb.vsync, vb.line_start, vb.frame_start, vb.vblank}),
                          int'(e.fl));
                end
            end
        end
        pend_b = vb.pix_tick;
        rstp_b = rst;
    end

    task automatic check_reset_state(input string tag);
        check({tag, ".a_flags"},
              int'({va.pix_tick, va.hsync, va.vsync, va.active, va.line_start, va.frame_start, va.vblank}),
              int'(7'b0110000));
        check({tag, ".a_xy"}, int'({va.x, va.y}), 0);
        check({tag, ".b_flags"},
              int'({vb.pix_tick, vb.hsync, vb.vsync, vb.active, vb.line_start, vb.frame_start, vb.vblank}),
              0);
        check({tag, ".b_xy"}, int'({vb.x, vb.y}), 0);
    endtask

    task automatic wait_xy_a(input int xx, input int yy, input int budget, input string name);
        int k;
        k = 0;
        while (!(int'(va.x) == xx && int'(va.y) == yy) && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (k >= budget) check(name, int'(va.x), xx);
    endtask

    initial begin
        int k;
        int bad;
        int xs;
        rst   = 1'b1;
        va.en = 1'b1;
        vb.en = 1'b1;

        pa(0,    0,   0, 6'b111110);
        pa(1,    1,   0, 6'b111000);
        pa(639,  639, 0, 6'b111000);
        pa(640,  0,   0, 6'b011000);
        pa(655,  0,   0, 6'b011000);
        pa(656,  0,   0, 6'b001000);
        pa(751,  0,   0, 6'b001000);
        pa(752,  0,   0, 6'b011000);
        pa(799,  0,   0, 6'b011000);
        pa(800,  0,   1, 6'b111100);
        pa(801,  1,   1, 6'b111000);
        pa(1100, 300, 1, 6'b111000);
        pa(1101, 301, 1, 6'b111000);

        pb(0,   0, 0, 6'b100110);
        pb(7,   7, 0, 6'b100000);
        pb(8,   0, 0, 6'b000000);
        pb(10,  0, 0, 6'b010000);
        pb(12,  0, 0, 6'b010000);
        pb(13,  0, 0, 6'b000000);
        pb(14,  0, 1, 6'b100100);
        pb(55,  0, 0, 6'b000000);
        pb(59,  0, 0, 6'b000001);
        pb(66,  0, 0, 6'b010001);
        pb(72,  0, 0, 6'b001001);
        pb(84,  0, 0, 6'b000101);
        pb(97,  0, 0, 6'b000001);
        pb(98,  0, 0, 6'b100110);
        pb(99,  1, 0, 6'b100000);
        pb(113, 1, 1, 6'b100000);

        repeat (3) @(posedge clk);
        #1;
        check_reset_state("rst_initial");
        rst = 1'b0;

        k = 0;
        while (n_b < 30 && k < 200) begin @(negedge clk); k++; end
        if (n_b < 30) check("b.reach_tick30", n_b, 30);
        @(posedge clk); #1;
        vb.en = 1'b0;
        xs  = int'(vb.x);
        bad = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (vb.pix_tick !== 1'b0 || int'(vb.x) != xs) bad++;
        end
        check("b.en_low_bad_cycles", bad, 0);
        vb.en = 1'b1;

        wait_xy_a(300, 1, 8000, "a.reach_x300_y1");
        @(posedge clk); #1;
        va.en = 1'b0;
        bad = 0;
        repeat (37) begin
            @(posedge clk); #1;
            if (int'(va.x) != 300 || va.pix_tick !== 1'b0) bad++;
        end
        check("a.freeze_bad_cycles", bad, 0);
        va.en = 1'b1;
        k = 0;
        while (int'(va.x) == 300 && k < 200) begin @(negedge clk); k++; end
        check("a.x_after_release", int'(va.x), 301);

        wait_xy_a(500, 1, 2000, "a.reach_x500_y1");
        check("a.queue_drained_before_rst", qa.size(), 0);
        check("b.queue_drained_before_rst", qb.size(), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_state("rst_midframe");
        pa(0, 0, 0, 6'b111110);
        rst = 1'b0;

        k = 0;
        while (qa.size() > 0 && k < 100) begin @(negedge clk); k++; end
        check("a.first_pixel_after_rst_seen", qa.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
